// File: rtl/countdown_ctrl.sv
// 8-bit countdown sequencer: loads N on START, ticks down to zero, pulses DONE,
// and optionally reloads for periodic operation.

module EQUAL_ZERO (
  input  logic [7:0] A,
  output logic       EQ
);
  assign EQ = ~(|A);
endmodule

module countdown_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] N,
  input  logic       AUTO,
  input  logic       HOLD,
  input  logic       ABORT,
  output logic [7:0] CNT,
  output logic       ZERO,
  output logic       TICK,
  output logic       BUSY,
  output logic       DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_zero;
  logic       w_tick;

  EQUAL_ZERO u_eq_zero (
    .A  (r_cnt),
    .EQ (w_zero)
  );

  // Next-state, next-count and TICK decode; ABORT outranks the zero test,
  // which outranks HOLD, so HOLD never stalls the exit from a zero count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tick      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_cnt_nxt   = N;
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt   = r_cnt;
        end
      end
      S_RUN: begin
        if (ABORT) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = S_IDLE;
        end else if (w_zero) begin
          w_state_nxt = S_FIN;
        end else if (HOLD) begin
          w_cnt_nxt   = r_cnt;
        end else begin
          w_cnt_nxt   = r_cnt - 8'd1;
          w_tick      = 1'b1;
        end
      end
      S_FIN: begin
        if (AUTO) begin
          w_cnt_nxt   = N;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and count registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign CNT  = r_cnt;
  assign ZERO = w_zero;
  assign TICK = w_tick;
  assign BUSY = (r_state == S_RUN) || (r_state == S_FIN);
  assign DONE = (r_state == S_FIN);

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl: per-cycle scoreboard against a
// behavioural model, plus scenario-level tick/DONE timing checks.

module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, auto_in, hold, abort;
  logic [7:0] n;
  logic [7:0] cnt;
  logic       zero, tick, busy, done;

  always #5 clk = ~clk;

  countdown_ctrl dut (
    .CLK   (clk),
    .RST   (rst),
    .START (start),
    .N     (n),
    .AUTO  (auto_in),
    .HOLD  (hold),
    .ABORT (abort),
    .CNT   (cnt),
    .ZERO  (zero),
    .TICK  (tick),
    .BUSY  (busy),
    .DONE  (done)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       zero;
    logic       tick;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_state = 0;   // 0 idle, 1 run, 2 fin
  int   m_cnt   = 0;
  int   cyc     = 0;
  int   tick_cnt, done_cnt, last_done_cyc, c0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, score outputs before the edge, advance model.
  task automatic step(input logic s, input logic [7:0] nv, input logic a,
                      input logic h, input logic ab, input logic r);
    exp_t e;
    exp_t o;
    start = s; n = nv; auto_in = a; hold = h; abort = ab; rst = r;
    e.cnt  = m_cnt[7:0];
    e.zero = (m_cnt == 0);
    e.busy = (m_state != 0);
    e.done = (m_state == 2);
    e.tick = (m_state == 1) && !ab && (m_cnt != 0) && !h;
    sb_q.push_back(e);
    #2;
    o = sb_q.pop_front();
    chk("cnt",  {24'd0, cnt},  {24'd0, o.cnt});
    chk("zero", {31'd0, zero}, {31'd0, o.zero});
    chk("tick", {31'd0, tick}, {31'd0, o.tick});
    chk("busy", {31'd0, busy}, {31'd0, o.busy});
    chk("done", {31'd0, done}, {31'd0, o.done});
    if (tick === 1'b1) tick_cnt++;
    if (done === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    if (r) begin
      m_state = 0;
      m_cnt   = 0;
    end else begin
      case (m_state)
        0: if (s) begin m_cnt = nv; m_state = 1; end
        1: begin
          if (ab) begin m_cnt = 0; m_state = 0; end
          else if (m_cnt == 0) m_state = 2;
          else if (!h) m_cnt = m_cnt - 1;
        end
        2: if (a) begin m_cnt = nv; m_state = 1; end else m_state = 0;
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic begin_scn();
    tick_cnt = 0; done_cnt = 0; last_done_cyc = -1; c0 = cyc;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; n = 8'h55; auto_in = 1'b0; hold = 1'b0; abort = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held two cycles with START asserted
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_cnt",  {24'd0, cnt},  32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    idle(2);

    // Basic N=3: DONE four edges after the START edge
    begin_scn();
    step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("basic_ticks", tick_cnt, 32'd3);
    chk("basic_dones", done_cnt, 32'd1);
    chk("basic_lat",   last_done_cyc - c0 - 1, 32'd4);
    chk("basic_busy",  {31'd0, busy}, 32'd0);

    // N=0: no ticks, DONE one cycle after RUN entry
    begin_scn();
    step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    chk("n0_ticks", tick_cnt, 32'd0);
    chk("n0_lat",   last_done_cyc - c0 - 1, 32'd1);

    // N=255: 255 ticks, no wrap (model scores every cycle)
    begin_scn();
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(260);
    chk("nff_ticks", tick_cnt, 32'd255);
    chk("nff_dones", done_cnt, 32'd1);
    chk("nff_lat",   last_done_cyc - c0 - 1, 32'd256);

    // N=5 with HOLD for 3 cycles at CNT=3
    begin_scn();
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    chk("hold_ticks", tick_cnt, 32'd5);
    chk("hold_lat",   last_done_cyc - c0 - 1, 32'd9);

    // HOLD when CNT is zero still proceeds to FIN
    begin_scn();
    step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("zhold_lat", last_done_cyc - c0 - 1, 32'd2);

    // ABORT (with HOLD) at CNT=2: back to IDLE, no DONE
    begin_scn();
    step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("abort_pre", {24'd0, cnt}, 32'd2);
    step(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(6);
    chk("abort_dones", done_cnt, 32'd0);
    chk("abort_ticks", tick_cnt, 32'd2);

    // Auto-reload N=2: DONE every 4 cycles, then AUTO dropped before third FIN
    begin_scn();
    step(1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("auto_dones_mid", done_cnt, 32'd2);
    chk("auto_period",    last_done_cyc - c0, 32'd8);
    for (int i = 0; i < 5; i++) step(1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("auto_dones", done_cnt, 32'd3);
    chk("auto_last",  last_done_cyc - c0, 32'd12);
    chk("auto_idle",  {31'd0, busy}, 32'd0);

    // START during RUN does not reload
    begin_scn();
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(6);
    chk("ign_ticks", tick_cnt, 32'd5);
    chk("ign_lat",   last_done_cyc - c0 - 1, 32'd6);

    // RST at CNT=4 of N=6: outputs reset, no DONE
    begin_scn();
    step(1'b1, 8'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("rstmid_pre", {24'd0, cnt}, 32'd4);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstmid_cnt",  {24'd0, cnt},  32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    idle(8);
    chk("rstmid_dones", done_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for an 8-bit countdown datapath built around the `EQUAL_ZERO` zero-detect component from `components.v`. It loads a count on a start request and decrements it once per enabled cycle, emitting one `TICK` per decrement. It terminates when `EQUAL_ZERO` flags the register as zero, then emits a one-cycle `DONE` pulse, optionally auto-reloading for periodic operation. Upstream sequencers use it as a timed-loop or delay primitive.

## Interface
- No parameters. Datapath width is fixed at 8 bits to match `EQUAL_ZERO`.
- `CLK`  input  1  system clock; all state changes on rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `START`  input  1  request to load `N` and begin counting; sampled only in IDLE.
- `N`  input  8  count to load; sampled on the `START` edge and on each auto-reload.
- `AUTO`  input  1  when 1 at the FIN cycle, reload `N` and keep running.
- `HOLD`  input  1  freezes `CNT` and suppresses `TICK` while in RUN.
- `ABORT`  input  1  cancels a RUN without `DONE`.
- `CNT`  output  8  current count register.
- `ZERO`  output  1  output of the internal `EQUAL_ZERO` instance on `CNT`.
- `TICK`  output  1  high in each RUN cycle in which a decrement is committed.
- `BUSY`  output  1  high in RUN or FIN.
- `DONE`  output  1  high for exactly the FIN cycle.

## Operation
- Reset values: state IDLE, `CNT`=0, `BUSY`=0, `DONE`=0, `TICK`=0, `ZERO`=1.
- The control priority order is `RST` > `ABORT` > `HOLD` > count.
- **IDLE**
  - `START`=1: `CNT`<=`N`, go to RUN.
  - Otherwise `CNT` holds.
- **RUN**
  - `ABORT`=1: `CNT`<=0, go to IDLE. No `DONE` and no `TICK` that cycle.
  - Else `ZERO`=1: go to FIN. `CNT` stays 0.
  - Else `HOLD`=1: no change, `TICK`=0.
  - Else: `CNT`<=`CNT`-1, `TICK`=1.
- **FIN**
  - `DONE`=1.
  - `AUTO`=1: `CNT`<=`N`, go to RUN.
  - `AUTO`=0: go to IDLE.
  - `ABORT` and `START` are ignored in FIN.
- `TICK` is combinational: RUN & ~`ABORT` & ~`ZERO` & ~`HOLD`.
- `DONE` and `BUSY` decode directly from state flops.
- `ZERO` must come from an instance of `EQUAL_ZERO`, not from a behavioural compare.
- Decrement is 8-bit unsigned. Underflow cannot occur because RUN never decrements at zero, and the bench checks this.
- `START` during RUN or FIN is ignored. It does not queue.

## Timing
- With `START` sampled at edge e0:
  - `CNT`=`N` after e0.
  - `CNT`=0 after edge eN.
  - FIN (`DONE`=1) between edges eN+1 and eN+2.
  - IDLE after eN+2.
- Start-to-`DONE` latency is N+1 cycles plus one cycle per `HOLD`ed RUN cycle. There are exactly N `TICK` cycles.
- `N`=0 gives no `TICK` and `DONE` one cycle after RUN entry.
- Auto-reload: `DONE` pulses once per period. The period is N+2 cycles with no `HOLD`, and RUN re-entry has no IDLE gap.
- `RST` mid-count: state and all outputs return to reset values on the next edge. No `DONE` is produced.
- `HOLD` and `ABORT` together: `ABORT` wins.
- `ZERO` and `HOLD` together in RUN: go to FIN, because `HOLD` only gates decrement.

## Test plan
- Reset: hold `RST` 2 cycles with `START`=1 and `N`=8'h55 -> `CNT`=0, `ZERO`=1, `BUSY`=0, `DONE`=0; IDLE after release.
- Basic count: `N`=3, `START` pulse -> `CNT` 3,2,1,0; three `TICK`s; `DONE` high exactly one cycle, 4 cycles after the `START` edge; then `BUSY`=0.
- Boundaries:
  - `N`=0 -> no `TICK`; `DONE` 1 cycle after RUN entry.
  - `N`=8'hFF -> 255 `TICK`s; `CNT` never wraps past 0.
- Hold/abort:
  - `N`=5 with `HOLD` for 3 cycles at `CNT`=3 -> `DONE` delayed 3 cycles; `TICK` count still 5.
  - `ABORT` at `CNT`=2 -> `CNT`=0, IDLE, no `DONE` pulse.
- Auto-reload: `AUTO`=1, `N`=2 -> `DONE` every 4 cycles; `BUSY` stays high. Dropping `AUTO` before a FIN -> return to IDLE after that `DONE`.
- Ignored events:
  - `START` during RUN does not reload.
  - `RST` asserted at `CNT`=4 of `N`=6 -> all outputs reset, no `DONE`.
